mem_instr_unit: RTL and testbench

MEM_INSTR_UNIT -- requirements
Module: mem_instr_unit

---
 rtl/gpu_pkg.sv | 47 ++++
 rtl/mem_instr_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_instr_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: instruction opcodes, MSB-first instruction field positions, memory unit FSM states.
// Latency: n/a (types, constants and a constant helper function only).
// Backpressure: n/a.
package gpu_pkg;

    // Instruction opcodes, shared with the controller.
    typedef enum logic [3:0] {
        OP_NOP       = 4'b0000,
        OP_END       = 4'b0001,
        OP_XOR       = 4'b0010,
        OP_ADDI      = 4'b0011,
        OP_BGE       = 4'b0100,
        OP_JUMP      = 4'b0101,
        OP_SMA       = 4'b0110,
        OP_LOADI     = 4'b0111,
        OP_SENDL     = 4'b1000,
        OP_LOADB     = 4'b1001,
        OP_LOAD      = 4'b1010,
        OP_WRITEB    = 4'b1011,
        OP_WRITE     = 4'b1100,
        OP_OR        = 4'b1101,
        OP_SENDITERS = 4'b1110
    } opcode_e;

    // Field positions counted MSB-first: position 0 is the instruction MSB.
    localparam int OPC_POS   = 0;
    localparam int OPC_BITS  = 4;
    localparam int REGA_POS  = 4;
    localparam int REGA_BITS = 4;
    localparam int IMM_POS   = 8;
    localparam int IMM_BITS  = 16;
    localparam int REGB_POS  = 24;
    localparam int REGB_BITS = 4;

    // Cache read sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_RD2  = 2'd2
    } rd_state_e;

    // Converts an MSB-first field position into the LSB index of a [W-1:0] vector.
    function automatic int field_lsb(input int instr_width, input int pos, input int bits);
        return instr_width - pos - bits;
    endfunction

endpackage

// File: rtl/mem_instr_unit.sv
// Memory instruction unit: decodes SMA/LOADI/SENDL/WRITEB/WRITE, owns the line buffer, drives cache BRAM and FMA operand line.
// Latency: SENDL/WRITE outputs 1 cycle after strobe; WRITEB fma_write_out 3 cycles after strobe (address shown in the issue cycle).
// Backpressure: none; busy_out high during a WRITEB read, instructions arriving then are dropped and overrun_out sticks high.
// Ports: clk_in/rst_in (sync, active-high); instr_in/instr_valid_in from controller; cache_* to external BRAM
//        (2-cycle read latency); fma_* operand line and flags to the FMA lanes; busy_out, overrun_out status.
module mem_instr_unit #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int DATA_CACHE_WIDTH  = 16,
    parameter int DATA_CACHE_DEPTH  = 4096,
    parameter int FMA_COUNT         = 2,
    localparam int LINE_WORDS       = 3 * FMA_COUNT,
    localparam int LINE_WIDTH       = LINE_WORDS * DATA_CACHE_WIDTH,
    localparam int ADDR_W           = $clog2(DATA_CACHE_DEPTH)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic                         instr_valid_in,
    output logic                         busy_out,
    output logic [ADDR_W-1:0]            cache_addr_out,
    output logic [LINE_WIDTH-1:0]        cache_din_out,
    output logic                         cache_we_out,
    input  logic [LINE_WIDTH-1:0]        cache_dout_in,
    output logic [LINE_WIDTH-1:0]        fma_line_out,
    output logic                         fma_write_out,
    output logic                         fma_replace_c_out,
    output logic                         fma_valid_out,
    output logic                         overrun_out
);
    import gpu_pkg::*;

    localparam int OPC_LSB  = field_lsb(INSTRUCTION_WIDTH, OPC_POS, OPC_BITS);
    localparam int REGA_LSB = field_lsb(INSTRUCTION_WIDTH, REGA_POS, REGA_BITS);
    localparam int IMM_LSB  = field_lsb(INSTRUCTION_WIDTH, IMM_POS, IMM_BITS);
    localparam int REGB_LSB = field_lsb(INSTRUCTION_WIDTH, REGB_POS, REGB_BITS);

    // Decoded fields
    opcode_e                     w_opcode;
    logic [REGA_BITS-1:0]        w_reg_a;
    logic [REGB_BITS-1:0]        w_reg_b;
    logic [ADDR_W-1:0]           w_imm_addr;
    logic [DATA_CACHE_WIDTH-1:0] w_imm_data;

    assign w_opcode   = opcode_e'(instr_in[OPC_LSB +: OPC_BITS]);
    assign w_reg_a    = instr_in[REGA_LSB +: REGA_BITS];
    assign w_reg_b    = instr_in[REGB_LSB +: REGB_BITS];
    // Immediate is truncated to the address/word width; upper bits wrap away.
    assign w_imm_addr = instr_in[IMM_LSB +: ADDR_W];
    assign w_imm_data = instr_in[IMM_LSB +: DATA_CACHE_WIDTH];

    // State
    rd_state_e                   r_state;
    rd_state_e                   w_state_nxt;
    logic [DATA_CACHE_WIDTH-1:0] r_line_buf [LINE_WORDS];
    logic [LINE_WIDTH-1:0]       w_line_packed;
    logic [ADDR_W-1:0]           r_mem_addr;
    logic [ADDR_W-1:0]           r_cache_addr;
    logic [LINE_WIDTH-1:0]       r_cache_din;
    logic                        r_cache_we;
    logic [LINE_WIDTH-1:0]       r_fma_line;
    logic                        r_fma_write;
    logic                        r_fma_replace_c;
    logic                        r_fma_valid;
    logic                        r_wb_replace_c;
    logic                        r_wb_valid;
    logic                        r_overrun;

    logic w_accept;
    logic w_drop;
    logic w_rd_issue;

    assign w_accept   = instr_valid_in && (r_state == ST_IDLE) && !rst_in;
    assign w_drop     = instr_valid_in && (r_state != ST_IDLE);
    assign w_rd_issue = w_accept && (w_opcode == OP_WRITEB);

    // Word i of the line sits at bits [i*W +: W]; lane i owns words 3i..3i+2.
    always_comb begin
        w_line_packed = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            w_line_packed[i*DATA_CACHE_WIDTH +: DATA_CACHE_WIDTH] = r_line_buf[i];
        end
    end

    // WRITEB read sequencer: the address is driven combinationally in the issue
    // cycle so the 2-cycle BRAM data lands exactly while the FSM is in RD2.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_rd_issue) w_state_nxt = ST_RD1;
            ST_RD1:  w_state_nxt = ST_RD2;
            ST_RD2:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_line_buf[i] <= '0;
            end
            r_mem_addr      <= '0;
            r_cache_addr    <= '0;
            r_cache_din     <= '0;
            r_cache_we      <= 1'b0;
            r_fma_line      <= '0;
            r_fma_write     <= 1'b0;
            r_fma_replace_c <= 1'b0;
            r_fma_valid     <= 1'b0;
            r_wb_replace_c  <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_cache_we  <= 1'b0;
            r_fma_write <= 1'b0;

            if (w_drop) begin
                r_overrun <= 1'b1;
            end

            // BRAM data is valid now; hand it to the FMAs with the flags latched at issue.
            if (r_state == ST_RD2) begin
                r_fma_line      <= cache_dout_in;
                r_fma_write     <= 1'b1;
                r_fma_replace_c <= r_wb_replace_c;
                r_fma_valid     <= r_wb_valid;
            end

            if (w_accept) begin
                case (w_opcode)
                    OP_SMA: r_mem_addr <= w_imm_addr;
                    OP_LOADI: begin
                        // Out-of-range word index matches no entry and is a no-op.
                        for (int i = 0; i < LINE_WORDS; i++) begin
                            if (int'(w_reg_a) == i) begin
                                r_line_buf[i] <= w_imm_data;
                            end
                        end
                    end
                    OP_SENDL: begin
                        r_cache_addr <= r_mem_addr;
                        r_cache_din  <= w_line_packed;
                        r_cache_we   <= 1'b1;
                    end
                    OP_WRITEB: begin
                        r_cache_addr   <= w_imm_addr;
                        r_wb_replace_c <= (w_reg_a != '0);
                        r_wb_valid     <= (w_reg_b != '0);
                    end
                    OP_WRITE: begin
                        r_fma_line      <= w_line_packed;
                        r_fma_write     <= 1'b1;
                        r_fma_replace_c <= (w_reg_a != '0);
                        r_fma_valid     <= (w_reg_b != '0);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_out          = (r_state != ST_IDLE);
    assign cache_addr_out    = w_rd_issue ? w_imm_addr : r_cache_addr;
    assign cache_din_out     = r_cache_din;
    assign cache_we_out      = r_cache_we;
    assign fma_line_out      = r_fma_line;
    assign fma_write_out     = r_fma_write;
    assign fma_replace_c_out = r_fma_replace_c;
    assign fma_valid_out     = r_fma_valid;
    assign overrun_out       = r_overrun;

endmodule

// File: tb/tb_mem_instr_unit.sv
// Directed testbench for mem_instr_unit with a 2-cycle-latency BRAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_instr_unit;

    localparam int IW = 32;
    localparam int DW = 16;
    localparam int DEPTH = 4096;
    localparam int FC = 2;
    localparam int LW = 3 * FC * DW;
    localparam int AW = 12;

    localparam logic [3:0] OPC_SMA    = 4'b0110;
    localparam logic [3:0] OPC_LOADI  = 4'b0111;
    localparam logic [3:0] OPC_SENDL  = 4'b1000;
    localparam logic [3:0] OPC_WRITEB = 4'b1011;
    localparam logic [3:0] OPC_WRITE  = 4'b1100;

    // Line after SMA/LOADI word0=0x0100, word5=0xFF00.
    localparam logic [LW-1:0] EXP_A = 96'hFF00_0000_0000_0000_0000_0100;
    localparam logic [LW-1:0] PAT_B = 96'h1111_2222_3333_4444_5555_6666;

    logic          clk = 1'b0;
    logic          rst_in;
    logic [IW-1:0] instr_in;
    logic          instr_valid_in;
    logic          busy_out;
    logic [AW-1:0] cache_addr_out;
    logic [LW-1:0] cache_din_out;
    logic          cache_we_out;
    logic [LW-1:0] cache_dout_in;
    logic [LW-1:0] fma_line_out;
    logic          fma_write_out;
    logic          fma_replace_c_out;
    logic          fma_valid_out;
    logic          overrun_out;

    int n_vec = 0;
    int n_err = 0;
    int fma_cnt = 0;
    int we_cnt = 0;

    always #5 clk = ~clk;

    mem_instr_unit #(
        .INSTRUCTION_WIDTH(IW),
        .DATA_CACHE_WIDTH (DW),
        .DATA_CACHE_DEPTH (DEPTH),
        .FMA_COUNT        (FC)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .instr_in         (instr_in),
        .instr_valid_in   (instr_valid_in),
        .busy_out         (busy_out),
        .cache_addr_out   (cache_addr_out),
        .cache_din_out    (cache_din_out),
        .cache_we_out     (cache_we_out),
        .cache_dout_in    (cache_dout_in),
        .fma_line_out     (fma_line_out),
        .fma_write_out    (fma_write_out),
        .fma_replace_c_out(fma_replace_c_out),
        .fma_valid_out    (fma_valid_out),
        .overrun_out      (overrun_out)
    );

    // BRAM model: read data appears two cycles after the address.
    logic [LW-1:0] mem [DEPTH];
    logic [LW-1:0] rd_p1;
    logic [LW-1:0] rd_p2;
    always @(posedge clk) begin
        if (cache_we_out) mem[cache_addr_out] <= cache_din_out;
        rd_p1 <= mem[cache_addr_out];
        rd_p2 <= rd_p1;
    end
    assign cache_dout_in = rd_p2;

    // Pulse counters, sampled at the edge closing each cycle.
    always @(posedge clk) begin
        if (fma_write_out === 1'b1) fma_cnt <= fma_cnt + 1;
        if (cache_we_out === 1'b1) we_cnt <= we_cnt + 1;
    end

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [3:0] ra,
                                         input logic [15:0] imm, input logic [3:0] rb);
        return {op, ra, imm, rb, 4'h0};
    endfunction

    // Called at a negedge; strobes one instruction and returns at the next negedge.
    task automatic issue(input logic [IW-1:0] w);
        instr_in = w;
        instr_valid_in = 1'b1;
        @(negedge clk);
        instr_valid_in = 1'b0;
        instr_in = '0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy_out); end
        n_vec++; if (cache_we_out !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0b want 0", cache_we_out); end
        n_vec++; if (cache_addr_out !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", cache_addr_out); end
        n_vec++; if (fma_write_out !== 1'b0) begin n_err++; $display("FAIL reset_fma_write: got %0b want 0", fma_write_out); end
        n_vec++; if (fma_line_out !== '0) begin n_err++; $display("FAIL reset_fma_line: got %h want 0", fma_line_out); end
        n_vec++; if (overrun_out !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %0b want 0", overrun_out); end
        rst_in = 1'b0;
        @(negedge clk);
    endtask

    // SMA wraps 0x1005 to 0x005; the second LOADI is immediately followed by SENDL.
    task automatic test_sendl();
        int base;
        issue(mk(OPC_SMA, 4'd0, 16'h1005, 4'd0));
        issue(mk(OPC_LOADI, 4'd0, 16'h0100, 4'd0));
        issue(mk(OPC_LOADI, 4'd5, 16'hFF00, 4'd0));
        base = we_cnt;
        issue(mk(OPC_SENDL, 4'd0, 16'h0000, 4'd0));
        n_vec++; if (cache_we_out !== 1'b1) begin n_err++; $display("FAIL sendl_we: got %0b want 1", cache_we_out); end
        n_vec++; if (cache_addr_out !== 12'h005) begin n_err++; $display("FAIL sendl_addr: got %h want 005", cache_addr_out); end
        n_vec++; if (cache_din_out !== EXP_A) begin n_err++; $display("FAIL sendl_din: got %h want %h", cache_din_out, EXP_A); end
        @(negedge clk);
        n_vec++; if (cache_we_out !== 1'b0) begin n_err++; $display("FAIL sendl_we_drop: got %0b want 0", cache_we_out); end
        n_vec++; if (we_cnt - base !== 1) begin n_err++; $display("FAIL sendl_pulses: got %0d want 1", we_cnt - base); end
    endtask

    // Reads back the line SENDL wrote to 0x005.
    task automatic test_writeb();
        int base;
        base = fma_cnt;
        instr_in = mk(OPC_WRITEB, 4'd1, 16'h0005, 4'd0);
        instr_valid_in = 1'b1;
        #1;
        n_vec++; if (cache_addr_out !== 12'h005) begin n_err++; $display("FAIL writeb_issue_addr: got %h want 005", cache_addr_out); end
        n_vec++; if (cache_we_out !== 1'b0) begin n_err++; $display("FAIL writeb_issue_we: got %0b want 0", cache_we_out); end
        @(negedge clk);
        instr_valid_in = 1'b0;
        instr_in = '0;
        n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL writeb_busy_rd1: got %0b want 1", busy_out); end
        @(negedge clk);
        n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL writeb_busy_rd2: got %0b want 1", busy_out); end
        n_vec++; if (fma_write_out !== 1'b0) begin n_err++; $display("FAIL writeb_early: got %0b want 0", fma_write_out); end
        @(negedge clk);
        n_vec++; if (fma_write_out !== 1'b1) begin n_err++; $display("FAIL writeb_strobe: got %0b want 1", fma_write_out); end
        n_vec++; if (fma_line_out !== EXP_A) begin n_err++; $display("FAIL writeb_line: got %h want %h", fma_line_out, EXP_A); end
        n_vec++; if (fma_replace_c_out !== 1'b1) begin n_err++; $display("FAIL writeb_replace: got %0b want 1", fma_replace_c_out); end
        n_vec++; if (fma_valid_out !== 1'b0) begin n_err++; $display("FAIL writeb_valid: got %0b want 0", fma_valid_out); end
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL writeb_busy_end: got %0b want 0", busy_out); end
        @(negedge clk);
        n_vec++; if (fma_write_out !== 1'b0) begin n_err++; $display("FAIL writeb_pulse_width: got %0b want 0", fma_write_out); end
        n_vec++; if (fma_line_out !== EXP_A) begin n_err++; $display("FAIL writeb_line_hold: got %h want %h", fma_line_out, EXP_A); end
        n_vec++; if (fma_cnt - base !== 1) begin n_err++; $display("FAIL writeb_pulses: got %0d want 1", fma_cnt - base); end
    endtask

    // LOADI to word 6 does not exist with two lanes; WRITE must show the untouched line.
    task automatic test_loadi_oob_write();
        issue(mk(OPC_LOADI, 4'd6, 16'hBEEF, 4'd0));
        issue(mk(OPC_WRITE, 4'd0, 16'h0000, 4'd1));
        n_vec++; if (fma_write_out !== 1'b1) begin n_err++; $display("FAIL write_strobe: got %0b want 1", fma_write_out); end
        n_vec++; if (fma_line_out !== EXP_A) begin n_err++; $display("FAIL write_line: got %h want %h", fma_line_out, EXP_A); end
        n_vec++; if (fma_valid_out !== 1'b1) begin n_err++; $display("FAIL write_valid: got %0b want 1", fma_valid_out); end
        n_vec++; if (fma_replace_c_out !== 1'b0) begin n_err++; $display("FAIL write_replace: got %0b want 0", fma_replace_c_out); end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        n_vec++; if (overrun_out !== 1'b0) begin n_err++; $display("FAIL overrun_pre: got %0b want 0", overrun_out); end
        issue(mk(OPC_WRITEB, 4'd0, 16'hF7AB, 4'd1));
        issue(mk(OPC_SMA, 4'd0, 16'h0123, 4'd0));
        n_vec++; if (overrun_out !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %0b want 1", overrun_out); end
        @(negedge clk);
        n_vec++; if (fma_write_out !== 1'b1) begin n_err++; $display("FAIL overrun_strobe: got %0b want 1", fma_write_out); end
        n_vec++; if (fma_line_out !== PAT_B) begin n_err++; $display("FAIL overrun_line: got %h want %h", fma_line_out, PAT_B); end
        n_vec++; if (fma_valid_out !== 1'b1) begin n_err++; $display("FAIL overrun_valid: got %0b want 1", fma_valid_out); end
        n_vec++; if (fma_replace_c_out !== 1'b0) begin n_err++; $display("FAIL overrun_replace: got %0b want 0", fma_replace_c_out); end
        issue(mk(OPC_SENDL, 4'd0, 16'h0000, 4'd0));
        n_vec++; if (cache_addr_out !== 12'h005) begin n_err++; $display("FAIL overrun_sma_dropped: got %h want 005", cache_addr_out); end
        n_vec++; if (overrun_out !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %0b want 1", overrun_out); end
        @(negedge clk);
    endtask

    task automatic test_ignored();
        logic [3:0] ops [10];
        int fb;
        int wb;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                4'b1001, 4'b1010, 4'b1101, 4'b1110};
        fb = fma_cnt;
        wb = we_cnt;
        for (int k = 0; k < 10; k++) begin
            issue(mk(ops[k], 4'd2, 16'h0ABC, 4'd3));
            n_vec++; if (cache_we_out !== 1'b0 || fma_write_out !== 1'b0 || busy_out !== 1'b0) begin
                n_err++; $display("FAIL ignored_op%0d: we=%0b fma=%0b busy=%0b want 0", ops[k], cache_we_out, fma_write_out, busy_out);
            end
        end
        repeat (3) @(negedge clk);
        n_vec++; if (fma_cnt !== fb || we_cnt !== wb) begin
            n_err++; $display("FAIL ignored_pulses: fma %0d we %0d want 0 0", fma_cnt - fb, we_cnt - wb);
        end
        n_vec++; if (fma_line_out !== PAT_B) begin n_err++; $display("FAIL ignored_line_hold: got %h want %h", fma_line_out, PAT_B); end
        issue(mk(OPC_SENDL, 4'd0, 16'h0000, 4'd0));
        n_vec++; if (cache_addr_out !== 12'h005) begin n_err++; $display("FAIL ignored_mem_addr: got %h want 005", cache_addr_out); end
        n_vec++; if (cache_din_out !== EXP_A) begin n_err++; $display("FAIL ignored_line_buf: got %h want %h", cache_din_out, EXP_A); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int base;
        base = fma_cnt;
        issue(mk(OPC_WRITEB, 4'd1, 16'h0005, 4'd1));
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %0b want 0", busy_out); end
        n_vec++; if (fma_write_out !== 1'b0) begin n_err++; $display("FAIL abort_fma_write: got %0b want 0", fma_write_out); end
        n_vec++; if (fma_line_out !== '0 || fma_replace_c_out !== 1'b0 || fma_valid_out !== 1'b0) begin
            n_err++; $display("FAIL abort_fma_outs: line %h rc %0b v %0b want 0", fma_line_out, fma_replace_c_out, fma_valid_out);
        end
        n_vec++; if (cache_addr_out !== '0 || cache_din_out !== '0 || cache_we_out !== 1'b0) begin
            n_err++; $display("FAIL abort_cache_outs: addr %h din %h we %0b want 0", cache_addr_out, cache_din_out, cache_we_out);
        end
        n_vec++; if (overrun_out !== 1'b0) begin n_err++; $display("FAIL abort_overrun: got %0b want 0", overrun_out); end
        repeat (4) @(negedge clk);
        n_vec++; if (fma_cnt !== base) begin n_err++; $display("FAIL abort_no_strobe: got %0d pulses want 0", fma_cnt - base); end
        issue(mk(OPC_SENDL, 4'd0, 16'h0000, 4'd0));
        n_vec++; if (cache_we_out !== 1'b1 || cache_addr_out !== '0 || cache_din_out !== '0) begin
            n_err++; $display("FAIL abort_state_clear: we %0b addr %h din %h want 1 0 0", cache_we_out, cache_addr_out, cache_din_out);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1;
        instr_in = '0;
        instr_valid_in = 1'b0;
        mem[12'h7AB] = PAT_B;
        @(negedge clk);
        test_reset();
        test_sendl();
        test_writeb();
        test_loadi_oob_write();
        test_overrun();
        test_ignored();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
